// File: rtl/tv80_reg_ctx.sv
// tv80_reg_ctx: context save/restore engine for the TV80 register file.
// Owns the register-file A-port. In IDLE the core drives it directly.
// A save streams pairs 0..LAST_IDX out on sv_*. A restore writes pairs
// 0..LAST_IDX from the rs_* stream. The core is stalled (busy) until the
// operation finishes.
//
// Handshakes: a transfer ("beat") happens on a rising edge where valid and
// ready are both high. A source holds its data stable while valid is high
// and ready is low. sv_valid does not depend on sv_ready. rs_ready does not
// depend on rs_valid.
module tv80_reg_ctx #(
  parameter int LAST_IDX = 7
) (
  input  logic        clk,
  input  logic        reset,
  // core side of the register file
  input  logic [2:0]  core_AddrA,
  input  logic [2:0]  core_AddrB,
  input  logic [2:0]  core_AddrC,
  input  logic [7:0]  core_DIH,
  input  logic [7:0]  core_DIL,
  input  logic        core_WEH,
  input  logic        core_WEL,
  input  logic        core_CEN,
  // register-file side
  output logic [2:0]  AddrA,
  output logic [2:0]  AddrB,
  output logic [2:0]  AddrC,
  output logic [7:0]  DIH,
  output logic [7:0]  DIL,
  output logic        WEH,
  output logic        WEL,
  output logic        CEN,
  input  logic [7:0]  DOAH,
  input  logic [7:0]  DOAL,
  // control
  input  logic        save_req,
  input  logic        restore_req,
  output logic        busy,
  output logic        done,
  // save stream
  output logic        sv_valid,
  input  logic        sv_ready,
  output logic [15:0] sv_data,
  output logic [2:0]  sv_idx,
  // restore stream
  input  logic        rs_valid,
  output logic        rs_ready,
  input  logic [15:0] rs_data,
  // debug: current FSM state (0 IDLE, 1 SAVE, 2 RESTORE, 3 DONE)
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] LAST = 3'(LAST_IDX);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;

  logic sv_beat;
  logic rs_beat;
  logic at_last;

  // A restore beat is suppressed in a reset cycle so that reset never
  // lands a stray write in the register file.
  assign sv_beat = (state_q == ST_SAVE) && sv_ready;
  assign rs_beat = (state_q == ST_RESTORE) && rs_valid && !reset;
  assign at_last = (idx_q == LAST);

  // Read ports B and C are never used by the engine.
  assign AddrB = core_AddrB;
  assign AddrC = core_AddrC;

  // Save data is the live A-port read of the current pair.
  assign sv_data     = {DOAH, DOAL};
  assign sv_idx      = idx_q;
  assign dbg_state_o = state_q;

  // State and pair-index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and index: requests only in IDLE, one pair per beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = 3'd0;
        if (save_req)         state_d = ST_SAVE;
        else if (restore_req) state_d = ST_RESTORE;
      end
      ST_SAVE: begin
        if (sv_beat) begin
          if (at_last) state_d = ST_DONE;
          else         idx_d   = idx_q + 3'd1;
        end
      end
      ST_RESTORE: begin
        if (rs_beat) begin
          if (at_last) state_d = ST_DONE;
          else         idx_d   = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A-port mux and status outputs, decoded from the registered state.
  always_comb begin
    AddrA    = idx_q;
    DIH      = rs_data[15:8];
    DIL      = rs_data[7:0];
    WEH      = 1'b0;
    WEL      = 1'b0;
    CEN      = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    sv_valid = 1'b0;
    rs_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        AddrA = core_AddrA;
        DIH   = core_DIH;
        DIL   = core_DIL;
        WEH   = core_WEH;
        WEL   = core_WEL;
        CEN   = core_CEN;
        busy  = 1'b0;
      end
      ST_SAVE: begin
        sv_valid = 1'b1;
      end
      ST_RESTORE: begin
        rs_ready = !reset;
        WEH      = rs_beat;
        WEL      = rs_beat;
        CEN      = rs_beat;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tv80_reg_ctx.sv
// Bench for tv80_reg_ctx: two instances (LAST_IDX 7 and 2), each with a
// behavioural register file. Expected save beats and scalar checks are
// queued by the stimulus process and compared by a single monitor.
module tb_tv80_reg_ctx;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (LAST_IDX = 7) ----------------
  logic [2:0]  core_AddrA, core_AddrB, core_AddrC;
  logic [7:0]  core_DIH, core_DIL;
  logic        core_WEH, core_WEL, core_CEN;
  logic [2:0]  AddrA, AddrB, AddrC;
  logic [7:0]  DIH, DIL, DOAH, DOAL;
  logic        WEH, WEL, CEN;
  logic        save_req, restore_req, busy, done;
  logic        sv_valid, sv_ready, rs_valid, rs_ready;
  logic [15:0] sv_data, rs_data;
  logic [2:0]  sv_idx;
  logic [1:0]  dbg_state;

  tv80_reg_ctx #(.LAST_IDX(7)) dut (
    .clk(clk), .reset(reset),
    .core_AddrA(core_AddrA), .core_AddrB(core_AddrB), .core_AddrC(core_AddrC),
    .core_DIH(core_DIH), .core_DIL(core_DIL),
    .core_WEH(core_WEH), .core_WEL(core_WEL), .core_CEN(core_CEN),
    .AddrA(AddrA), .AddrB(AddrB), .AddrC(AddrC),
    .DIH(DIH), .DIL(DIL), .WEH(WEH), .WEL(WEL), .CEN(CEN),
    .DOAH(DOAH), .DOAL(DOAL),
    .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done),
    .sv_valid(sv_valid), .sv_ready(sv_ready), .sv_data(sv_data), .sv_idx(sv_idx),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data),
    .dbg_state_o(dbg_state)
  );

  // register file 1: one write port, combinational A read
  logic [7:0] rf_h[8];
  logic [7:0] rf_l[8];
  int         wr_cnt;
  assign DOAH = rf_h[AddrA];
  assign DOAL = rf_l[AddrA];
  always @(posedge clk) begin
    if (CEN && (WEH || WEL)) wr_cnt <= wr_cnt + 1;
    if (CEN && WEH) rf_h[AddrA] <= DIH;
    if (CEN && WEL) rf_l[AddrA] <= DIL;
  end

  // ---------------- DUT 2 (LAST_IDX = 2) ----------------
  logic [2:0]  core_AddrA2, core_AddrB2, core_AddrC2;
  logic [7:0]  core_DIH2, core_DIL2;
  logic        core_WEH2, core_WEL2, core_CEN2;
  logic [2:0]  AddrA2, AddrB2, AddrC2;
  logic [7:0]  DIH2, DIL2, DOAH2, DOAL2;
  logic        WEH2, WEL2, CEN2;
  logic        save_req2, restore_req2, busy2, done2;
  logic        sv_valid2, sv_ready2, rs_valid2, rs_ready2;
  logic [15:0] sv_data2, rs_data2;
  logic [2:0]  sv_idx2;
  logic [1:0]  dbg_state2;

  tv80_reg_ctx #(.LAST_IDX(2)) dut2 (
    .clk(clk), .reset(reset),
    .core_AddrA(core_AddrA2), .core_AddrB(core_AddrB2), .core_AddrC(core_AddrC2),
    .core_DIH(core_DIH2), .core_DIL(core_DIL2),
    .core_WEH(core_WEH2), .core_WEL(core_WEL2), .core_CEN(core_CEN2),
    .AddrA(AddrA2), .AddrB(AddrB2), .AddrC(AddrC2),
    .DIH(DIH2), .DIL(DIL2), .WEH(WEH2), .WEL(WEL2), .CEN(CEN2),
    .DOAH(DOAH2), .DOAL(DOAL2),
    .save_req(save_req2), .restore_req(restore_req2),
    .busy(busy2), .done(done2),
    .sv_valid(sv_valid2), .sv_ready(sv_ready2), .sv_data(sv_data2), .sv_idx(sv_idx2),
    .rs_valid(rs_valid2), .rs_ready(rs_ready2), .rs_data(rs_data2),
    .dbg_state_o(dbg_state2)
  );

  logic [7:0] rf2_h[8];
  logic [7:0] rf2_l[8];
  assign DOAH2 = rf2_h[AddrA2];
  assign DOAL2 = rf2_l[AddrA2];
  always @(posedge clk) begin
    if (CEN2 && WEH2) rf2_h[AddrA2] <= DIH2;
    if (CEN2 && WEL2) rf2_l[AddrA2] <= DIL2;
  end

  // ---------------- reference model and scoreboard ----------------
  logic [15:0] ref_rf[8];     // expected register-file contents, DUT 1
  logic [15:0] ref2[8];       // expected contents, DUT 2
  logic [15:0] rs_vals[8];    // restore stream payload for the next restore
  logic [18:0] exp_q[$];      // expected {idx, data} save beats, DUT 1
  logic [18:0] exp2_q[$];     // expected save beats, DUT 2
  string       chk_name_q[$];
  logic [31:0] chk_got_q[$];
  logic [31:0] chk_exp_q[$];
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_name_q.push_back(name);
    chk_got_q.push_back(got);
    chk_exp_q.push_back(exp);
  endtask

  // monitor: every cycle a save stream is valid, its beat must match the
  // head of the expected queue; the head pops on an accepted beat
  initial begin
    total = 0;
    bad   = 0;
    forever begin
      @(negedge clk);
      if (!reset && sv_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sv_beat_unexpected got=%h exp=none", {sv_idx, sv_data});
        end else begin
          if ({sv_idx, sv_data} !== exp_q[0]) begin
            bad++;
            $display("FAIL sv_beat got=%h exp=%h", {sv_idx, sv_data}, exp_q[0]);
          end
          if (sv_ready) void'(exp_q.pop_front());
        end
      end
      if (!reset && sv_valid2) begin
        total++;
        if (exp2_q.size() == 0) begin
          bad++;
          $display("FAIL sv2_beat_unexpected got=%h exp=none", {sv_idx2, sv_data2});
        end else begin
          if ({sv_idx2, sv_data2} !== exp2_q[0]) begin
            bad++;
            $display("FAIL sv2_beat got=%h exp=%h", {sv_idx2, sv_data2}, exp2_q[0]);
          end
          if (sv_ready2) void'(exp2_q.pop_front());
        end
      end
      if (done) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL done_without_busy got=%b exp=1", busy);
        end
      end
      while (chk_name_q.size() > 0) begin
        string       nm;
        logic [31:0] g, e;
        nm = chk_name_q.pop_front();
        g  = chk_got_q.pop_front();
        e  = chk_exp_q.pop_front();
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL %s got=%0h exp=%0h", nm, g, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input bit rnd);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      ref_rf[n]  = rnd ? 16'($urandom) : 16'h1100 + 16'(n);
      core_AddrA = 3'(n);
      core_DIH   = ref_rf[n][15:8];
      core_DIL   = ref_rf[n][7:0];
      core_WEH   = 1'b1;
      core_WEL   = 1'b1;
      core_CEN   = 1'b1;
    end
    @(posedge clk); #1;
    core_WEH = 1'b0;
    core_WEL = 1'b0;
    core_CEN = 1'b0;
  endtask

  task automatic check_rf();
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      core_AddrA = 3'(n);
      @(negedge clk);
      chk("rf_readback", 32'({DOAH, DOAL}), 32'(ref_rf[n]));
    end
  endtask

  // mode 0: always ready; 1: stall 5 cycles at idx 3; 2: random stalls
  task automatic do_save(input int mode, input bit both);
    int   beats, stalls, bcnt, done_at, hold, w0;
    bit   rdy, finished;
    logic [2:0] ab, ac;
    beats = 0; stalls = 0; bcnt = 0; done_at = 0; hold = 0; w0 = 0;
    finished = 1'b0;
    for (int n = 0; n < 8; n++) exp_q.push_back({3'(n), ref_rf[n]});
    if (both) begin
      core_AddrA  = 3'd6;
      core_DIH    = ref_rf[6][15:8];
      core_DIL    = ref_rf[6][7:0];
      core_WEH    = 1'b1;
      core_WEL    = 1'b1;
      core_CEN    = 1'b1;
      restore_req = 1'b1;
    end
    save_req = 1'b1;
    sv_ready = 1'b0;
    @(posedge clk); #1;
    save_req    = 1'b0;
    restore_req = 1'b0;
    ab = 3'($urandom);
    ac = 3'($urandom);
    core_AddrB = ab;
    core_AddrC = ac;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(beats == 3 && hold < 5);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      if (mode == 1 && !rdy) hold++;
      sv_ready = rdy;
      if (beats < 8) begin
        if (rdy) beats++;
        else     stalls++;
      end
      @(negedge clk);
      if (cyc == 1) begin
        w0 = wr_cnt;
        chk("save_busy_rise", 32'(busy), 1);
        chk("save_rs_ready_low", 32'(rs_ready), 0);
        chk("save_addrb", 32'(AddrB), 32'(ab));
        chk("save_addrc", 32'(AddrC), 32'(ac));
      end
      if (busy) bcnt++;
      if (done) done_at = cyc;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    core_WEH = 1'b0;
    core_WEL = 1'b0;
    core_CEN = 1'b0;
    sv_ready = 1'b0;
    chk("save_finished", 32'(finished), 1);
    chk("save_busy_cycles", 32'(bcnt), 32'(9 + stalls));
    chk("save_done_cycle", 32'(done_at), 32'(9 + stalls));
    chk("save_no_write", 32'(wr_cnt - w0), 0);
    @(negedge clk);
    chk("save_queue_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // mode 0: valid on alternate cycles; 1: always valid; 2: random
  task automatic do_restore(input int mode, input int abort_after);
    int beats, gaps, bcnt, done_at, w0;
    bit v, finished, aborted;
    beats = 0; gaps = 0; bcnt = 0; done_at = 0;
    finished = 1'b0;
    aborted  = 1'b0;
    w0 = wr_cnt;
    restore_req = 1'b1;
    rs_valid    = 1'b0;
    @(posedge clk); #1;
    restore_req = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (abort_after >= 0 && beats == abort_after) begin
        reset    = 1'b1;
        rs_valid = 1'b1;
        rs_data  = rs_vals[beats];
        @(posedge clk); #1;
        reset    = 1'b0;
        rs_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rs_ready", 32'(rs_ready), 0);
        chk("abort_sv_valid", 32'(sv_valid), 0);
        chk("abort_state_idle", 32'(dbg_state), 0);
        chk("abort_writes", 32'(wr_cnt - w0), 32'(abort_after));
        aborted = 1'b1;
        break;
      end
      case (mode)
        0:       v = (cyc % 2 == 0);
        1:       v = 1'b1;
        default: v = 1'(($urandom_range(0, 1)));
      endcase
      rs_valid = v;
      rs_data  = (beats < 8) ? rs_vals[beats] : 16'($urandom);
      if (beats < 8) begin
        if (v) begin
          ref_rf[beats] = rs_vals[beats];
          beats++;
        end else begin
          gaps++;
        end
      end
      @(negedge clk);
      if (busy) bcnt++;
      if (done) done_at = cyc;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    rs_valid = 1'b0;
    if (!aborted) begin
      chk("restore_finished", 32'(finished), 1);
      chk("restore_busy_cycles", 32'(bcnt), 32'(9 + gaps));
      chk("restore_done_cycle", 32'(done_at), 32'(9 + gaps));
      chk("restore_writes", 32'(wr_cnt - w0), 8);
    end
    check_rf();
  endtask

  // LAST_IDX=2 instance: request held across DONE gives two saves
  // separated by exactly one IDLE cycle
  task automatic save2_b2b();
    logic [12:1] busy_m, done_m, exp_b, exp_d;
    int dones;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      ref2[n]     = 16'($urandom);
      core_AddrA2 = 3'(n);
      core_DIH2   = ref2[n][15:8];
      core_DIL2   = ref2[n][7:0];
      core_WEH2   = 1'b1;
      core_WEL2   = 1'b1;
      core_CEN2   = 1'b1;
    end
    @(posedge clk); #1;
    core_WEH2 = 1'b0;
    core_WEL2 = 1'b0;
    core_CEN2 = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int n = 0; n < 3; n++) exp2_q.push_back({3'(n), ref2[n]});
    // op of 3 beats + done occupies 4 cycles; second op starts after 1 idle
    for (int c = 1; c <= 12; c++) begin
      exp_b[c] = (c <= 4) || (c >= 6 && c <= 9);
      exp_d[c] = (c == 4) || (c == 9);
    end
    busy_m = '0;
    done_m = '0;
    dones  = 0;
    sv_ready2 = 1'b1;
    save_req2 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      busy_m[cyc] = busy2;
      done_m[cyc] = done2;
      if (done2) begin
        dones++;
        if (dones == 2) save_req2 = 1'b0;
      end
      @(posedge clk); #1;
    end
    save_req2 = 1'b0;
    chk("dut2_busy_pattern", 32'(busy_m), 32'(exp_b));
    chk("dut2_done_pattern", 32'(done_m), 32'(exp_d));
    repeat (6) @(negedge clk);
    chk("dut2_queue_drained", 32'(exp2_q.size()), 0);
    exp2_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    core_AddrA = '0; core_AddrB = '0; core_AddrC = '0;
    core_DIH = '0; core_DIL = '0; core_WEH = 1'b0; core_WEL = 1'b0; core_CEN = 1'b0;
    save_req = 1'b0; restore_req = 1'b0; sv_ready = 1'b0; rs_valid = 1'b0; rs_data = '0;
    core_AddrA2 = '0; core_AddrB2 = '0; core_AddrC2 = '0;
    core_DIH2 = '0; core_DIL2 = '0; core_WEH2 = 1'b0; core_WEL2 = 1'b0; core_CEN2 = 1'b0;
    save_req2 = 1'b0; restore_req2 = 1'b0; sv_ready2 = 1'b0; rs_valid2 = 1'b0; rs_data2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_sv_valid", 32'(sv_valid), 0);
    chk("reset_rs_ready", 32'(rs_ready), 0);
    chk("reset_state", 32'(dbg_state), 0);
    chk("reset_dut2_idle", 32'({busy2, done2, rs_ready2, AddrB2, AddrC2, dbg_state2}), 0);

    // idle pass-through of the A-port
    @(posedge clk); #1;
    core_AddrA = 3'd5; core_DIH = 8'h3c; core_DIL = 8'hc3;
    core_WEH = 1'b1; core_WEL = 1'b0; core_CEN = 1'b0;
    @(negedge clk);
    chk("idle_pass_a", 32'({AddrA, DIH, DIL, WEH, WEL, CEN}), 32'({3'd5, 8'h3c, 8'hc3, 3'b100}));
    core_WEH = 1'b0;

    // directed: preload 0x1100+n, zero-stall save
    preload(1'b0);
    check_rf();
    do_save(0, 1'b0);

    // directed: alternate-cycle restore of 0xA0B0+n
    for (int n = 0; n < 8; n++) rs_vals[n] = 16'hA0B0 + 16'(n);
    do_restore(0, -1);

    // both requests together with core write enables held high
    do_save(0, 1'b1);

    // 5-cycle stall at idx 3
    do_save(1, 1'b0);

    // reset after 4 restore beats, then a save from idx 0
    for (int n = 0; n < 8; n++) rs_vals[n] = 16'($urandom);
    do_restore(1, 4);
    do_save(0, 1'b0);

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      preload(1'b1);
      do_save(2, 1'b0);
      for (int n = 0; n < 8; n++) rs_vals[n] = 16'($urandom);
      do_restore(2, -1);
      do_save(2, 1'b0);
    end

    // short configuration, back-to-back
    save2_b2b();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
